// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the fetch (IF)
// and memory-stage (D) requesters. D has priority unless D won the last grant.
`timescale 1ns/1ps
module unified_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_abort,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_d_q, last_d_d;
    logic               abort_q, abort_d;
    logic               if_ready_q, if_ready_d;
    logic               d_ready_q, d_ready_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic if_elig, d_elig, grant_d, grant_i;

    // A requester is ignored in its own ready cycle; a flushed fetch is never granted.
    assign if_elig = if_req & ~if_ready_q & ~if_abort;
    assign d_elig  = d_req & ~d_ready_q;
    assign grant_d = d_elig & (~if_elig | ~last_d_q);
    assign grant_i = if_elig & ~grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_d_q    <= 1'b1;
            abort_q     <= 1'b0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_d_q    <= last_d_d;
            abort_q     <= abort_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        abort_d     = abort_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (grant_d) begin
                    state_d     = BUSY_D;
                    cnt_d       = CNT_INIT;
                    last_d_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (grant_i) begin
                    state_d    = BUSY_I;
                    cnt_d      = CNT_INIT;
                    last_d_d   = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            BUSY_I: begin
                if (if_abort) abort_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // An abort arriving in the final busy cycle still suppresses delivery.
                    if (!(abort_q || if_abort)) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                    abort_d  = 1'b0;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            BUSY_D: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!mem_we_q) d_rdata_d = mem_rdata;
                    d_ready_d = 1'b1;
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = d_req & ~d_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table plus hand sequences,
// ready pulses checked against a scoreboard of expected data and cycle.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_abort, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ready, d_ready, stall_if, stall_mem, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    // Second instance at MEM_LATENCY=1, fetch side only.
    logic        if1_req, if1_abort, d1_req, d1_we;
    logic [31:0] if1_addr, d1_addr, d1_wdata;
    logic        if1_ready, d1_ready, stall_if1, stall_mem1, mem1_en, mem1_we;
    logic [31:0] if1_rdata, d1_rdata, mem1_addr, mem1_wdata, mem1_rdata;

    int checks = 0, failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if1_req), .if_addr(if1_addr), .if_abort(if1_abort),
        .if_ready(if1_ready), .if_rdata(if1_rdata),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_ready(d1_ready), .d_rdata(d1_rdata),
        .stall_if(stall_if1), .stall_mem(stall_mem1),
        .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr),
        .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (32'hC0DE0000 ^ a);
    endfunction

    // Memory model: unwritten words hold pat(addr).
    logic [31:0] wmem [0:63];
    logic [63:0] wvalid = '0;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wmem[mem_addr[7:2]]   <= mem_wdata;
            wvalid[mem_addr[7:2]] <= 1'b1;
        end
    end
    assign mem_rdata  = wvalid[mem_addr[7:2]] ? wmem[mem_addr[7:2]] : pat(mem_addr);
    assign mem1_rdata = pat(mem1_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    exp_t if_sb[$], d_sb[$];
    exp_t mon_e;
    logic if_seen, d_seen;
    logic [31:0] exp_if = '0, exp_d = '0;

    always @(negedge clk) begin
        if (if_ready) begin
            if_seen = 1'b1;
            chkb("stall_if_in_ready", stall_if, 1'b0);
            if (if_sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL if_ready_unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
                mon_e = if_sb.pop_front();
                chk("if_rdata", if_rdata, mon_e.data);
                chk("if_ready_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        if (d_ready) begin
            d_seen = 1'b1;
            chkb("stall_mem_in_ready", stall_mem, 1'b0);
            if (d_sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL d_ready_unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
                mon_e = d_sb.pop_front();
                chk("d_rdata", d_rdata, mon_e.data);
                chk("d_ready_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        if (if_ready || d_ready) begin
            chkb("ready_exclusive", if_ready & d_ready, 1'b0);
            chkb("mem_en_in_ready", mem_en, 1'b0);
        end
    end

    typedef struct {
        logic        ifreq;
        logic [31:0] ifaddr;
        logic        dreq, dwe;
        logic [31:0] daddr, dwdata, dexp;
        int          if_off, d_off;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic ifreq, input logic [31:0] ifaddr,
                                input logic dreq, input logic dwe, input logic [31:0] daddr,
                                input logic [31:0] dwdata, input logic [31:0] dexp,
                                input int if_off, input int d_off);
        vec_t v;
        v.ifreq = ifreq; v.ifaddr = ifaddr; v.dreq = dreq; v.dwe = dwe;
        v.daddr = daddr; v.dwdata = dwdata; v.dexp = dexp;
        v.if_off = if_off; v.d_off = d_off;
        return v;
    endfunction

    task automatic wait_done(input string name);
        logic done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            if (if_seen) if_req = 1'b0;
            if (d_seen)  d_req  = 1'b0;
            done = !if_req && !d_req;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: got requests still pending expected completion (cycle %0d)", name, cyc);
            if_req = 1'b0;
            d_req  = 1'b0;
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int t0;
        @(posedge clk); #1;
        t0 = cyc;
        if_seen = 1'b0; d_seen = 1'b0;
        if_req = v.ifreq; if_addr = v.ifaddr;
        d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
        if (v.ifreq) begin
            exp_if = pat(v.ifaddr);
            if_sb.push_back('{data: exp_if, cyc: t0 + v.if_off});
        end
        if (v.dreq) begin
            if (!v.dwe) exp_d = v.dexp;
            d_sb.push_back('{data: exp_d, cyc: t0 + v.d_off});
        end
        @(negedge clk);
        chkb("stall_if_issue", stall_if, v.ifreq);
        chkb("stall_mem_issue", stall_mem, v.dreq);
        wait_done("vector");
    endtask

    // Cycle-by-cycle view of one D access: port held for two busy cycles.
    task automatic detail_d(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rexp);
        int t0;
        @(posedge clk); #1;
        t0 = cyc;
        d_seen = 1'b0;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        if (!we) exp_d = rexp;
        d_sb.push_back('{data: exp_d, cyc: t0 + 3});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chkb("detail_mem_en", mem_en, (k == 1 || k == 2));
            chkb("detail_stall_mem", stall_mem, (k < 3));
            if (k == 1 || k == 2) begin
                chk("detail_mem_addr", mem_addr, addr);
                chkb("detail_mem_we", mem_we, we);
                if (we) chk("detail_mem_wdata", mem_wdata, wdata);
            end
            @(posedge clk); #1;
            if (k == 3) d_req = 1'b0;
        end
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        if_req = 0; if_abort = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        if1_req = 0; if1_abort = 0; if1_addr = '0;
        d1_req = 0; d1_we = 0; d1_addr = '0; d1_wdata = '0;
        if_seen = 0; d_seen = 0;

        //          ifreq ifaddr  dreq we daddr   dwdata         dexp           if d
        vecs.push_back(mk(0, 32'h00, 1, 0, 32'h40, 32'h0,         32'hDEADBEEF,  0, 3));
        vecs.push_back(mk(1, 32'h00, 1, 0, 32'h80, 32'h0,         pat(32'h80),   3, 6));
        vecs.push_back(mk(1, 32'h04, 1, 0, 32'h84, 32'h0,         pat(32'h84),   3, 6));
        vecs.push_back(mk(0, 32'h00, 1, 1, 32'h10, 32'h12345678,  32'h0,         0, 3));
        vecs.push_back(mk(0, 32'h00, 1, 0, 32'h10, 32'h0,         32'h12345678,  0, 3));
        vecs.push_back(mk(1, 32'h08, 0, 0, 32'h00, 32'h0,         32'h0,         3, 0));
        vecs.push_back(mk(1, 32'h0C, 1, 0, 32'h20, 32'h0,         pat(32'h20),   6, 3));
        vecs.push_back(mk(1, 32'h14, 1, 1, 32'h24, 32'hAABBCCDD,  32'h0,         6, 3));
        vecs.push_back(mk(0, 32'h00, 1, 0, 32'h24, 32'h0,         32'hAABBCCDD,  0, 3));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chkb("rst_if_ready", if_ready, 1'b0);
        chkb("rst_d_ready", d_ready, 1'b0);
        chkb("rst_mem_en", mem_en, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);

        detail_d(1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        foreach (vecs[i]) apply_vec(vecs[i]);
        detail_d(1'b1, 32'h30, 32'h0BADF00D, 32'h0);

        // Fetch aborted while busy; a D request arriving meanwhile waits.
        @(posedge clk); #1;
        t0 = cyc;
        if_seen = 0; d_seen = 0;
        if_req = 1; if_addr = 32'h18;
        @(posedge clk); #1;
        if_abort = 1; d_req = 1; d_we = 0; d_addr = 32'h28;
        exp_d = pat(32'h28);
        d_sb.push_back('{data: exp_d, cyc: t0 + 6});
        @(negedge clk); chkb("abort_mem_en_c1", mem_en, 1'b1);
        @(posedge clk); #1;
        if_abort = 0; if_req = 0;
        @(negedge clk); chkb("abort_mem_en_c2", mem_en, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chkb("abort_mem_en_c3", mem_en, 1'b0);
        chkb("abort_no_if_ready", if_ready, 1'b0);
        chk("abort_if_rdata_kept", if_rdata, exp_if);
        wait_done("abort_d");

        // Abort in IDLE blocks the grant for that cycle only.
        @(posedge clk); #1;
        if_seen = 0;
        if_req = 1; if_addr = 32'h1C; if_abort = 1;
        @(posedge clk); #1;
        t0 = cyc;
        if_abort = 0;
        exp_if = pat(32'h1C);
        if_sb.push_back('{data: exp_if, cyc: t0 + 3});
        @(negedge clk); chkb("idle_abort_no_grant", mem_en, 1'b0);
        wait_done("idle_abort");

        // Reset during a D read abandons it without a ready pulse.
        @(posedge clk); #1;
        d_seen = 0;
        d_req = 1; d_we = 0; d_addr = 32'h44; d_wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; d_req = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chkb("midrst_d_ready", d_ready, 1'b0);
        chkb("midrst_mem_en", mem_en, 1'b0);
        chkb("midrst_mem_we", mem_we, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_wdata", mem_wdata, 32'h0);
        chk("midrst_d_rdata", d_rdata, 32'h0);
        chk("midrst_if_rdata", if_rdata, 32'h0);
        exp_d = '0;
        apply_vec(mk(1, 32'h08, 0, 0, 32'h0, 32'h0, 32'h0, 3, 0));

        // MEM_LATENCY=1: back-to-back fetches, one idle ready cycle between.
        @(posedge clk); #1;
        if1_req = 1; if1_addr = 32'h0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chkb("l1_if_ready", if1_ready, (k == 2 || k == 5));
            chkb("l1_d_ready", d1_ready, 1'b0);
            if (k == 2 || k == 5) begin
                chkb("l1_mem_en_in_ready", mem1_en, 1'b0);
                chk("l1_if_rdata", if1_rdata, (k == 2) ? pat(32'h0) : pat(32'h4));
            end else if (k == 1 || k == 4) begin
                chkb("l1_mem_en_busy", mem1_en, 1'b1);
                chk("l1_mem_addr", mem1_addr, (k == 1) ? 32'h0 : 32'h4);
            end
            @(posedge clk); #1;
            if (k == 2) if1_addr = 32'h4;
            if (k == 5) if1_req = 0;
        end

        repeat (4) @(posedge clk);
        chk("sb_if_drained", 32'(if_sb.size()), 32'h0);
        chk("sb_d_drained", 32'(d_sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
